// File: rtl/gpr_write_scheduler.sv
// Arbitrates the GPR file write port between the in-order writeback stage and a
// long-latency result FIFO, and tracks per-register busy state for ID-stage stalls.
module gpr_write_scheduler #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_en,
  input  logic [4:0]  wb_rw,
  input  logic [31:0] wb_data,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_rw,
  input  logic [31:0] lu_data,
  input  logic        issue_req,
  input  logic [4:0]  issue_rw,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  output logic        stall,
  output logic        gpr_we,
  output logic [4:0]  gpr_rw,
  output logic [31:0] gpr_wd,
  output logic [31:0] busy_vec
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    rw_mem_q   [DEPTH];
  logic [4:0]    rw_mem_d   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [31:0]   data_mem_d [DEPTH];
  logic [31:0]   busy_q, busy_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  logic          empty, full, wb_act, pop, push, hz, starve, issue_ok;
  logic [4:0]    head_rw;
  logic [31:0]   head_data;

  // FIFO status and port arbitration; writeback always wins when it targets a real register
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    head_rw   = rw_mem_q[rd_ptr_q[AW-1:0]];
    head_data = data_mem_q[rd_ptr_q[AW-1:0]];
    wb_act    = reset && wb_en && (wb_rw != 5'd0);
    pop       = !empty && !wb_act;
    push      = lu_valid && !full;

    gpr_we = 1'b0;
    gpr_rw = 5'd0;
    gpr_wd = 32'd0;
    if (wb_act) begin
      gpr_we = 1'b1;
      gpr_rw = wb_rw;
      gpr_wd = wb_data;
    end else if (!empty && (head_rw != 5'd0)) begin
      gpr_we = 1'b1;
      gpr_rw = head_rw;
      gpr_wd = head_data;
    end
  end

  // Hazard detection and stall generation
  always_comb begin
    hz = ((rs != 5'd0) && busy_q[rs]) ||
         ((rt != 5'd0) && busy_q[rt]) ||
         (issue_req && (issue_rw != 5'd0) && busy_q[issue_rw]);
    starve   = (starve_cnt_q == CW'(STARVE_LIMIT));
    stall    = hz || starve;
    issue_ok = issue_req && !stall && (issue_rw != 5'd0);
    lu_ready = !full;
    busy_vec = busy_q;
  end

  // Next-state: FIFO storage/pointers, scoreboard (set beats clear), starvation counter
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    rw_mem_d   = rw_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      rw_mem_d[wr_ptr_q[AW-1:0]]   = lu_rw;
      data_mem_d[wr_ptr_q[AW-1:0]] = lu_data;
    end

    busy_d = busy_q;
    if (pop) begin
      busy_d[head_rw] = 1'b0;
    end
    if (issue_ok) begin
      busy_d[issue_rw] = 1'b1;
    end
    busy_d[0] = 1'b0;

    starve_cnt_d = starve_cnt_q;
    if (empty || pop) begin
      starve_cnt_d = CW'(0);
    end else if (!starve) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= PW'(0);
      rd_ptr_q     <= PW'(0);
      busy_q       <= 32'd0;
      starve_cnt_q <= CW'(0);
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rw_mem_q[i]   <= 5'd0;
        data_mem_q[i] <= 32'd0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      busy_q       <= busy_d;
      starve_cnt_q <= starve_cnt_d;
      rw_mem_q     <= rw_mem_d;
      data_mem_q   <= data_mem_d;
    end
  end

endmodule

// File: tb/tb_gpr_write_scheduler.sv
// Scoreboard bench for gpr_write_scheduler: directed scenarios then random traffic,
// checked against a queue-based reference model.
module tb_gpr_write_scheduler;

  localparam int unsigned DEPTH        = 2;
  localparam int unsigned STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rw = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        lu_valid = 1'b0;
  logic        lu_ready;
  logic [4:0]  lu_rw = 5'd0;
  logic [31:0] lu_data = 32'd0;
  logic        issue_req = 1'b0;
  logic [4:0]  issue_rw = 5'd0;
  logic [4:0]  rs = 5'd0;
  logic [4:0]  rt = 5'd0;
  logic        stall;
  logic        gpr_we;
  logic [4:0]  gpr_rw;
  logic [31:0] gpr_wd;
  logic [31:0] busy_vec;

  gpr_write_scheduler #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .wb_en(wb_en), .wb_rw(wb_rw), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rw(lu_rw), .lu_data(lu_data),
    .issue_req(issue_req), .issue_rw(issue_rw), .rs(rs), .rt(rt),
    .stall(stall), .gpr_we(gpr_we), .gpr_rw(gpr_rw), .gpr_wd(gpr_wd),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rw;
    logic [31:0] wd;
    logic        chk_data;
    logic        stall;
    logic        lu_ready;
    logic [31:0] busy;
  } exp_t;

  typedef struct {
    logic [4:0]  rw;
    logic [31:0] d;
  } ent_t;

  exp_t        exp_q[$];
  ent_t        mq[$];
  logic [31:0] mbusy = 32'd0;
  int          mcnt = 0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
    end
  endtask

  // Monitor: compares DUT outputs mid-cycle against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("gpr_we", 32'(gpr_we), 32'(e.we));
        if (e.chk_data) begin
          chk("gpr_rw", 32'(gpr_rw), 32'(e.rw));
          chk("gpr_wd", gpr_wd, e.wd);
        end
        chk("stall", 32'(stall), 32'(e.stall));
        chk("lu_ready", 32'(lu_ready), 32'(e.lu_ready));
        chk("busy_vec", busy_vec, e.busy);
      end
    end
  end

  // Reference model: predict this cycle's outputs from current inputs, then advance one edge
  task automatic step();
    exp_t e;
    logic wb_act, pop, push, hz;
    int   sz;
    sz = mq.size();
    e.we = 1'b0; e.rw = 5'd0; e.wd = 32'd0; e.chk_data = 1'b1;
    if (!reset) begin
      mq.delete();
      mbusy = 32'd0;
      mcnt  = 0;
      e.stall = 1'b0; e.lu_ready = 1'b1; e.busy = 32'd0;
      exp_q.push_back(e);
    end else begin
      wb_act = wb_en && (wb_rw != 5'd0);
      if (wb_act) begin
        e.we = 1'b1; e.rw = wb_rw; e.wd = wb_data;
      end else if (sz > 0) begin
        if (mq[0].rw != 5'd0) begin
          e.we = 1'b1; e.rw = mq[0].rw; e.wd = mq[0].d;
        end else begin
          e.chk_data = 1'b0;
        end
      end
      hz = ((rs != 0) && mbusy[rs]) || ((rt != 0) && mbusy[rt]) ||
           (issue_req && (issue_rw != 0) && mbusy[issue_rw]);
      e.stall    = hz || (mcnt == STARVE_LIMIT);
      e.lu_ready = (sz < DEPTH);
      e.busy     = mbusy;
      exp_q.push_back(e);

      pop  = !wb_act && (sz > 0);
      push = lu_valid && (sz < DEPTH);
      if (sz == 0 || pop) mcnt = 0;
      else if (mcnt < STARVE_LIMIT) mcnt = mcnt + 1;
      if (pop) begin
        mbusy[mq[0].rw] = 1'b0;
        void'(mq.pop_front());
      end
      if (push) mq.push_back('{lu_rw, lu_data});
      if (issue_req && !e.stall && (issue_rw != 0)) mbusy[issue_rw] = 1'b1;
      mbusy[0] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_en = 1'b0; wb_rw = 5'd0; wb_data = 32'd0;
    lu_valid = 1'b0; lu_rw = 5'd0; lu_data = 32'd0;
    issue_req = 1'b0; issue_rw = 5'd0; rs = 5'd0; rt = 5'd0;
  endtask

  task automatic push_lu(input logic [4:0] r, input logic [31:0] d);
    lu_valid = 1'b1; lu_rw = r; lu_data = d;
  endtask

  initial begin
    @(posedge clk);
    #1;
    step(); step();
    reset = 1'b1;
    idle(); step();

    // Issue to r5, RAW stall on it, long result completes it
    issue_req = 1'b1; issue_rw = 5'd5; step();
    idle(); rs = 5'd5; step();
    idle(); push_lu(5'd5, 32'hDEADBEEF); step();
    idle(); step(); step(); step();

    // Writeback holds the port long enough to force starvation
    wb_en = 1'b1; wb_rw = 5'd3; wb_data = 32'h0000_0033; push_lu(5'd10, 32'hA0A0_0010); step();
    lu_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin wb_data = 32'(i); step(); end
    idle(); step(); step();

    // Fill the FIFO behind a busy writeback, third result must be refused
    wb_en = 1'b1; wb_rw = 5'd3; wb_data = 32'h0000_0003;
    push_lu(5'd11, 32'h1111_1111); step();
    push_lu(5'd12, 32'h2222_2222); step();
    push_lu(5'd13, 32'h3333_3333); step();
    idle(); step(); step(); step(); step();

    // WAW on r7: reissue stalls until the pending r7 result drains
    issue_req = 1'b1; issue_rw = 5'd7; step();
    step();
    push_lu(5'd7, 32'h7777_7777); step();
    lu_valid = 1'b0; step(); step(); step();
    idle(); step();

    // Writeback to r0 yields the port; a long result to r0 pops silently
    wb_en = 1'b1; wb_rw = 5'd2; wb_data = 32'h22; push_lu(5'd9, 32'h9999_0009); step();
    lu_valid = 1'b0; wb_rw = 5'd0; wb_data = 32'hFFFF_FFFF; step();
    idle(); push_lu(5'd0, 32'hBAD0_0000); step();
    idle(); step(); step();

    // Reset with pending results and busy registers
    issue_req = 1'b1; issue_rw = 5'd4; wb_en = 1'b1; wb_rw = 5'd1; wb_data = 32'h1;
    push_lu(5'd14, 32'hEEEE_0014); step();
    issue_req = 1'b0; push_lu(5'd15, 32'hFFFF_0015); step();
    idle(); reset = 1'b0; step(); step();
    reset = 1'b1; step(); step(); step();

    // Random traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      reset     = ($urandom_range(0, 149) != 0);
      wb_en     = ($urandom_range(0, 9) < 6);
      wb_rw     = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      lu_valid  = ($urandom_range(0, 9) < 4);
      lu_rw     = 5'($urandom_range(0, 7));
      lu_data   = $urandom;
      issue_req = ($urandom_range(0, 9) < 3);
      issue_rw  = 5'($urandom_range(0, 7));
      rs        = 5'($urandom_range(0, 7));
      rt        = 5'($urandom_range(0, 7));
      step();
    end
    reset = 1'b1;
    idle(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpr_write_scheduler.md
Name: gpr_write_scheduler

Overview:
- Shares the single general-purpose register file write port between two sources: the in-order pipeline writeback stage, and a multi-cycle long-latency unit (mult/div, uncached load return) that completes out of order.
- Holds pending long-unit results in a small FIFO and keeps a per-register busy scoreboard.
- Drives the ID-stage stall for RAW/WAW hazards and for writeback-port starvation.
- Sits between MEM/WB and the register file write port (we/rw/Wd).

Parameters:
- DEPTH, 2, long-unit result FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may be denied the port before a forced drain.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- wb_en  in  1  pipeline writeback request; always granted, never back-pressured
- wb_rw  in  5  pipeline writeback destination
- wb_data  in  32  pipeline writeback data
- lu_valid  in  1  long-unit result valid
- lu_ready  out  1  FIFO can accept (= !full)
- lu_rw  in  5  long-unit destination
- lu_data  in  32  long-unit result
- issue_req  in  1  ID stage wants to issue a long-unit op (unqualified by stall)
- issue_rw  in  5  destination of that op
- rs  in  5  ID source register 1
- rt  in  5  ID source register 2
- stall  out  1  freeze PC/IF/ID, insert bubble into EX
- gpr_we  out  1  register file write enable
- gpr_rw  out  5  register file write address
- gpr_wd  out  32  register file write data
- busy_vec  out  32  scoreboard, for debug

Behaviour:
- Reset (async, reset=0):
  - FIFO empty, all busy bits 0, starve counter 0.
  - Outputs: lu_ready=1, stall=0, gpr_we=0, gpr_rw=0, gpr_wd=0, busy_vec=0.
  - Reset mid-operation discards all pending FIFO entries; they are never written.
- Port selection (combinational, same cycle):
  - If wb_en and wb_rw≠0: gpr_we=1, gpr_rw/gpr_wd=wb_rw/wb_data; the FIFO is not popped.
  - Else if FIFO non-empty: gpr_we=1, drive the head entry; the head pops at the clock edge.
  - Else gpr_we=0, gpr_rw=0, gpr_wd=0.
  - A writeback to r0 counts as no request. FIFO entries with rw=0 pop with gpr_we=0.
- FIFO:
  - Push on lu_valid && lu_ready.
  - Minimum latency push→register-file write is 1 cycle (no same-cycle bypass).
  - Pointers wrap modulo DEPTH; full/empty use an extra pointer bit.
  - Simultaneous push and pop when full is not allowed, since lu_ready=0 when full. Push and pop in the same cycle when non-full: count unchanged.
  - lu_valid while !lu_ready is ignored; the long unit holds its data.
- Scoreboard:
  - Define hz = (rs≠0 && busy[rs]) || (rt≠0 && busy[rt]) || (issue_req && issue_rw≠0 && busy[issue_rw]).
  - busy[issue_rw] is set at the edge when issue_req && !stall && issue_rw≠0.
  - busy[x] is cleared at the edge when a FIFO entry with rw=x pops.
  - Set and clear of the same register in one cycle cannot occur (the issue is stalled by hz); if it does, set wins.
  - A pipeline writeback to a busy register does not clear its busy bit.
  - busy[0] is hardwired to 0.
- Starvation:
  - The counter increments when the FIFO is non-empty and no pop occurs. It resets to 0 on any pop or when the FIFO is empty. It saturates at STARVE_LIMIT.
  - starve = (counter == STARVE_LIMIT).
  - stall = hz || starve, combinational from the current state and inputs.
  - While starve=1, bubbles drain the pipeline, wb_en eventually drops, and the FIFO pops.
- Registers update only on posedge clk or negedge reset. There is no combinational path from lu_valid to lu_ready.

Test Plan:
- Reset, then issue_req with issue_rw=5 → busy_vec=0x20. Next cycle rs=5 → stall=1. lu_valid with rw=5, data=0xDEADBEEF, wb_en=0 → next cycle gpr_we=1, rw=5, wd=0xDEADBEEF. Edge after that: busy_vec=0, stall=0.
- FIFO holds one entry and wb_en=1 (rw=3) held for 4 cycles → gpr_we tracks the WB source throughout. Counter reaches 4 → stall=1. Drop wb_en → FIFO entry written, stall=0, counter=0.
- Push 2 entries with wb_en=1 held → lu_ready=0 after the second push; a third lu_valid is not accepted. Release WB → entries written in push order. After each pop lu_ready=1.
- issue_req with rw=7 while busy[7]=1 → stall=1 and busy is not re-set. FIFO entry with rw=7 popped → stall falls the following cycle, issue succeeds, busy[7]=1.
- wb_en=1, wb_rw=0, FIFO head rw=9 → FIFO head written the same cycle. Long-unit entry with rw=0 → popped with gpr_we=0.
- Assert reset while 2 entries pending and busy_vec≠0 → immediately gpr_we=0, busy_vec=0, lu_ready=1. After release, no stale writes occur.
